// File: rtl/fib_pair_serializer.sv
// rtl/fib_pair_serializer.sv - pair FIFO that serializes {a,b} words and flags non-monotonic output
// Pairs are stored whole; a half-select bit picks which word of the head pair is presented.
module fib_pair_serializer #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_a,
   input  logic [W-1:0]           in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_data,
   output logic                   out_wrap,
   output logic                   wrapped,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem_a [DEPTH];
   logic [W-1:0] mem_b [DEPTH];
   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;
   logic         half;
   logic [W-1:0] last;
   logic         push;
   logic         xfer;
   logic         pop;

   // Occupancy comes straight from the pointers, so it clears the instant rst rises.
   assign count     = wr_ptr - rd_ptr;
   assign in_ready  = (count != (PW+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;
   assign pop       = xfer & half;
   assign out_data  = half ? mem_b[rd_ptr[PW-1:0]] : mem_a[rd_ptr[PW-1:0]];
   assign out_wrap  = out_valid & (out_data < last);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr[PW-1:0]] <= in_a;
         mem_b[wr_ptr[PW-1:0]] <= in_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         half    <= 1'b0;
         last    <= '0;
         wrapped <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (xfer) begin
            half <= ~half;
            last <= out_data;
            if (out_wrap)
               wrapped <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// tb/tb_fib_pair_serializer.sv - scoreboard bench for fib_pair_serializer
// The driver queues expected words on accepted pushes; the monitor checks every visible output.
module tb_fib_pair_serializer;

   localparam int W     = 16;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_wrap;
   logic         wrapped;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] q[$];
   logic [W-1:0] m_last = '0;
   logic         m_wrapped = 1'b0;
   logic         mon_en = 1'b0;
   logic         toggling = 1'b0;

   fib_pair_serializer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_wrap(out_wrap), .wrapped(wrapped), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: head word, wrap flag, occupancy and handshakes derived from the word queue.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         int exp_cnt;
         exp_cnt = (q.size() + 1) / 2;
         chk("count", 32'(count), 32'(exp_cnt));
         chk("count_le_depth", 32'(count <= DEPTH), 32'd1);
         chk("in_ready", 32'(in_ready), 32'(exp_cnt != DEPTH));
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("wrapped", 32'(wrapped), 32'(m_wrapped));
         if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0]));
            chk("out_wrap", 32'(out_wrap), 32'(q[0] < m_last));
            if (out_ready) begin
               if (q[0] < m_last)
                  m_wrapped = 1'b1;
               m_last = q[0];
               q.delete(0);
            end
         end else begin
            chk("out_wrap_idle", 32'(out_wrap), 32'd0);
         end
      end
   end

   // Entered and left at posedge+1.
   task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (ok) begin
         @(posedge clk);
         q.push_back(a);
         q.push_back(b);
         #1;
      end else begin
         checks++;
         failures++;
         $display("FAIL push_timeout actual=in_ready_low required=accept pair %0d,%0d", a, b);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d words left required=0", q.size());
      end
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_wrapped", 32'(wrapped), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Ordering
      out_ready = 1'b1;
      push_pair(16'd1, 16'd1);
      push_pair(16'd2, 16'd3);
      push_pair(16'd5, 16'd8);
      drain();

      // Mid-pair stall
      out_ready = 1'b0;
      push_pair(16'd13, 16'd21);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_data", 32'(out_data), 32'd21);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_count", 32'(count), 32'd1);
      end
      @(posedge clk);
      #1;
      drain();

      // Full / backpressure
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         push_pair(W'(30 + 10 * i), W'(35 + 10 * i));
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(count), 32'(DEPTH));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push_pair(16'd100, 16'd110);
      drain();

      // Wrap
      push_pair(16'd28657, 16'd46368);
      push_pair(16'd9489, 16'd55857);
      drain();
      chk("wrapped_sticky", 32'(wrapped), 32'd1);

      // Async reset mid-pair
      out_ready = 1'b0;
      push_pair(16'd200, 16'd300);
      push_pair(16'd400, 16'd500);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      q.delete();
      m_last = '0;
      m_wrapped = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_wrapped", 32'(wrapped), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_out_wrap", 32'(out_wrap), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      push_pair(16'd1, 16'd1);
      drain();

      // Pointer wrap-around with toggling out_ready
      out_ready = 1'b1;
      toggling = 1'b1;
      fork
         begin
            while (toggling) begin
               @(posedge clk);
               #1;
               out_ready = ~out_ready;
            end
         end
         begin
            for (int i = 0; i < 3 * DEPTH; i++) begin
               push_pair(W'($urandom), W'($urandom));
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #0;
            end
            toggling = 1'b0;
         end
      join
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fib_pair_serializer.md
# fib_pair_serializer

Downstream consumer for the double-rate Fibonacci generator. It accepts a pair of words per transfer, `in_a` then `in_b`, through a valid/ready handshake, and buffers pairs in a small FIFO. It emits one word per cycle on a valid/ready output stream, in sequence order. It also flags any point where the emitted sequence stops being non-decreasing, which marks 16-bit wrap-around of the generator.

## Interface
- `W`, 16: data word width.
- `DEPTH`, 4: FIFO capacity in pairs; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  a pair is presented on `in_a`/`in_b`.
- `in_ready`  out  1  the block can accept a pair this cycle.
- `in_a`  in  W  first (older) word of the pair.
- `in_b`  in  W  second (newer) word of the pair.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  the sink accepts the word this cycle.
- `out_data`  out  W  current output word.
- `out_wrap`  out  1  qualified by `out_valid`; current word < last emitted word.
- `wrapped`  out  1  sticky; set when a word with `out_wrap`=1 is transferred.
- `count`  out  $clog2(DEPTH)+1  number of pairs stored, including a partially emitted head pair.

## Operation
- Storage: circular FIFO of DEPTH entries, each {a, b}. Write and read pointers carry one extra wrap bit. full = `count`==DEPTH; empty = `count`==0.
- Push: on `in_valid & in_ready`, write {`in_a`,`in_b`} at the write pointer and advance it.
- `in_ready` = !full. It is driven from registered state only; there is no combinational path from `out_ready`.
- Head select bit `half`:
  - 0 → `out_data` = head.a.
  - 1 → `out_data` = head.b.
- Output transfer (`out_valid & out_ready`):
  - If `half`=0, set `half`=1.
  - If `half`=1, set `half`=0, pop the head pair and advance the read pointer.
- `out_valid` = !empty.
- Stall: `out_data` and `out_wrap` hold stable while `out_valid & !out_ready`.
- Wrap detection:
  - Register `last` holds the last transferred word.
  - `out_wrap` = `out_valid` & (`out_data` < `last`), unsigned compare.
  - `last` updates on every output transfer.
  - `wrapped` sets on a transfer with `out_wrap`=1 and clears only on reset.
- `count` update:
  - Increments on push.
  - Decrements on pop of the b half.
  - Both in one cycle → unchanged.
- Reset (async, any time, including mid-pair): pointers=0, `half`=0, `last`=0, `wrapped`=0, `count`=0. Consequently `out_valid`=0, `out_wrap`=0 and `in_ready`=1 while `rst` is high, independent of `clk`. FIFO contents need no reset.

## Timing
- Latency: a pair pushed at edge t produces `out_valid`=1 with word a after t. a transfers at the earliest at edge t+1, b at t+2. There is no input-to-output bypass.
- Throughput: output 1 word/cycle. Sustained input ≤ 1 pair per 2 cycles; bursts up to DEPTH pairs absorbed.
- Simultaneous push and b-pop when full: push is refused (`in_ready`=0 that cycle). `in_ready` rises the cycle after the pop.
- Simultaneous push and b-pop when `count`=1: the new pair becomes head on the next cycle. `out_valid` stays 1 with `half`=0.
- Pointer wrap at DEPTH: indices roll modulo DEPTH. The wrap bit distinguishes full from empty.
- First word after reset compares against `last`=0, so it never sets `out_wrap`.

## Test plan
- **Ordering:** push (1,1),(2,3),(5,8) back-to-back with `out_ready`=1 → `out_data` sequence 1,1,2,3,5,8 on consecutive transfers, `out_wrap`=0 throughout, `count` returns to 0.
- **Full/backpressure:** DEPTH=4, `out_ready`=0, push 5 pairs → first 4 accepted, `in_ready`=0 after the 4th, `count`=4. Raise `out_ready` → 8 words out in order. `in_ready`=1 the cycle after the first b-pop.
- **Mid-pair stall:** push (13,21), transfer 13, drop `out_ready` for 3 cycles → `out_data`=21, `out_valid`=1 stable, `count`=1. Restore → 21 transfers, `count`=0.
- **Wrap:** push (28657,46368),(9489,55857) → `out_wrap`=1 only while 9489 is presented. `wrapped` goes 1 after that transfer and stays 1.
- **Async reset mid-operation:** 2 pairs stored and `half`=1, assert `rst` between clock edges → `out_valid`=0, `count`=0, `wrapped`=0 immediately. After release, push (1,1) → output 1,1.
- **Pointer wrap-around:** stream 3×DEPTH pairs with `out_ready` toggling 1,0 → every word emitted once in order, no loss or duplication, `count` never exceeds DEPTH.
